// File: rtl/mult8_seq_ctrl.sv
// Purpose: unsigned 8x8 -> 16-bit product built from four 4x4 partial products on one shared external multiplier.
// Latency: accept edge to out_valid is 4*(MUL_LAT+1) cycles; best throughput is one product per 4*(MUL_LAT+1)+2 cycles.
// Backpressure: DONE holds out_valid/out_p until out_ready; in_ready stays low until the cycle after the product is taken.
//
// Ports:
//   clk, rst_n            clock (rising edge) and asynchronous active-low reset
//   in_valid/in_ready     request handshake; in_a (multiplicand), in_b (multiplier) sampled on accept
//   out_valid/out_ready   product handshake; out_p holds the 16-bit product while out_valid is high
//   mul_x, mul_y, mul_o   shared 4x4 multiplier operands (registered) and its result, MUL_LAT cycles later
//   busy                  high whenever the sequencer is not idle
module mult8_seq_ctrl #(
    parameter int MUL_LAT = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  in_a,
    input  logic [7:0]  in_b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_p,
    output logic [3:0]  mul_x,
    output logic [3:0]  mul_y,
    input  logic [7:0]  mul_o,
    output logic        busy
);

    // The wait counter reaches this value on the cycle the multiplier result for the current step is valid.
    localparam logic [1:0] LAST_WAIT = 2'(MUL_LAT);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;

    logic [7:0]  a_q;
    logic [7:0]  b_q;
    logic [15:0] acc;
    logic [1:0]  step;
    logic [1:0]  wait_cnt;

    logic        step_last;
    logic [15:0] shifted;
    logic [3:0]  nxt_x;
    logic [3:0]  nxt_y;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and handshake outputs
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b1;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (step_last && (step == 2'd3)) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Partial-product alignment and the operand pair for the step that follows the current one.
    always_comb begin
        step_last = (wait_cnt == LAST_WAIT);

        shifted = 16'd0;
        case (step)
            2'd0:       shifted = {8'd0, mul_o};
            2'd1, 2'd2: shifted = {4'd0, mul_o, 4'd0};
            default:    shifted = {mul_o, 8'd0};
        endcase

        // After step 3 the operands drop back to zero for DONE.
        nxt_x = 4'd0;
        nxt_y = 4'd0;
        case (step)
            2'd0: begin
                nxt_x = a_q[3:0];
                nxt_y = b_q[7:4];
            end
            2'd1: begin
                nxt_x = a_q[7:4];
                nxt_y = b_q[3:0];
            end
            2'd2: begin
                nxt_x = a_q[7:4];
                nxt_y = b_q[7:4];
            end
            default: begin
                nxt_x = 4'd0;
                nxt_y = 4'd0;
            end
        endcase
    end

    // Datapath: operand latch, registered multiplier operands, step/wait counters, accumulator.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q      <= 8'd0;
            b_q      <= 8'd0;
            acc      <= 16'd0;
            step     <= 2'd0;
            wait_cnt <= 2'd0;
            mul_x    <= 4'd0;
            mul_y    <= 4'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_q      <= in_a;
                        b_q      <= in_b;
                        acc      <= 16'd0;
                        step     <= 2'd0;
                        wait_cnt <= 2'd0;
                        // Step 0 operands come straight from the request so they are live in the first RUN cycle.
                        mul_x    <= in_a[3:0];
                        mul_y    <= in_b[3:0];
                    end
                end
                RUN: begin
                    if (step_last) begin
                        // Maximum true sum is 0xFE01, so the 16-bit add never wraps.
                        acc      <= acc + shifted;
                        wait_cnt <= 2'd0;
                        step     <= step + 2'd1;
                        mul_x    <= nxt_x;
                        mul_y    <= nxt_y;
                    end else begin
                        wait_cnt <= wait_cnt + 2'd1;
                    end
                end
                default: begin
                    mul_x <= 4'd0;
                    mul_y <= 4'd0;
                end
            endcase
        end
    end

    // acc is frozen in DONE, which keeps out_p stable under backpressure.
    assign out_p = acc;

endmodule

// File: tb/tb_mult8_seq_ctrl.sv
// Bench for mult8_seq_ctrl: one instance with a combinational 4x4 multiplier (MUL_LAT=0)
// and one with a two-stage pipelined multiplier (MUL_LAT=2), both fed the same request stream.
module tb_mult8_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_a = 8'd0;
    logic [7:0]  in_b = 8'd0;
    logic        out_ready = 1'b1;

    logic        in_ready0, out_valid0, busy0;
    logic [15:0] out_p0;
    logic [3:0]  mul_x0, mul_y0;
    logic [7:0]  mul_o0;

    logic        in_ready2, out_valid2, busy2;
    logic [15:0] out_p2;
    logic [3:0]  mul_x2, mul_y2;
    logic [7:0]  mul_o2;
    logic [7:0]  pp1 = 8'd0;
    logic [7:0]  pp2 = 8'd0;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    mult8_seq_ctrl #(.MUL_LAT(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0),
        .in_a(in_a), .in_b(in_b), .out_valid(out_valid0), .out_ready(out_ready),
        .out_p(out_p0), .mul_x(mul_x0), .mul_y(mul_y0), .mul_o(mul_o0), .busy(busy0)
    );

    mult8_seq_ctrl #(.MUL_LAT(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready2),
        .in_a(in_a), .in_b(in_b), .out_valid(out_valid2), .out_ready(out_ready),
        .out_p(out_p2), .mul_x(mul_x2), .mul_y(mul_y2), .mul_o(mul_o2), .busy(busy2)
    );

    // Shared multipliers: combinational, and two register stages.
    assign mul_o0 = {4'd0, mul_x0} * {4'd0, mul_y0};
    always @(posedge clk) begin
        pp1 <= {4'd0, mul_x2} * {4'd0, mul_y2};
        pp2 <= pp1;
    end
    assign mul_o2 = pp2;

    // Instance-indexed views of the DUT outputs.
    logic        rdy_v [2];
    logic        vld_v [2];
    logic        busy_v [2];
    logic [15:0] p_v [2];
    logic [3:0]  x_v [2];
    logic [3:0]  y_v [2];
    assign rdy_v[0] = in_ready0;   assign rdy_v[1] = in_ready2;
    assign vld_v[0] = out_valid0;  assign vld_v[1] = out_valid2;
    assign busy_v[0] = busy0;      assign busy_v[1] = busy2;
    assign p_v[0] = out_p0;        assign p_v[1] = out_p2;
    assign x_v[0] = mul_x0;        assign x_v[1] = mul_x2;
    assign y_v[0] = mul_y0;        assign y_v[1] = mul_y2;

    function automatic int lat_of(input int i);
        return (i == 0) ? 0 : 2;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", name, got, want);
        end
    endtask

    // Behavioural model: phase 0 idle, 1 computing (cycle countdown), 2 holding the product.
    int          m_phase [2] = '{0, 0};
    int          m_cnt [2] = '{0, 0};
    logic [7:0]  m_a [2] = '{8'd0, 8'd0};
    logic [7:0]  m_b [2] = '{8'd0, 8'd0};
    logic [15:0] m_prod [2] = '{16'd0, 16'd0};
    logic [15:0] exp_mem [2][1024];
    int          acc_cnt [2] = '{0, 0};
    int          hs_cnt [2] = '{0, 0};

    always @(posedge clk or negedge rst_n) begin
        for (int i = 0; i < 2; i++) begin
            if (!rst_n) begin
                m_phase[i] = 0;
                m_cnt[i]   = 0;
                acc_cnt[i] = hs_cnt[i];
            end else begin
                case (m_phase[i])
                    0: if (in_valid) begin
                        m_phase[i] = 1;
                        m_cnt[i]   = 4 * (lat_of(i) + 1);
                        m_a[i]     = in_a;
                        m_b[i]     = in_b;
                        m_prod[i]  = {8'd0, in_a} * {8'd0, in_b};
                        exp_mem[i][acc_cnt[i] % 1024] = m_prod[i];
                        acc_cnt[i]++;
                    end
                    1: begin
                        m_cnt[i]--;
                        if (m_cnt[i] == 0) m_phase[i] = 2;
                    end
                    default: if (out_ready) m_phase[i] = 0;
                endcase
            end
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            int   l1, e, s;
            logic [3:0] ex, ey;
            ex = 4'd0;
            ey = 4'd0;
            if (m_phase[i] == 1) begin
                l1 = lat_of(i) + 1;
                e  = 4 * l1 - m_cnt[i];
                s  = e / l1;
                ex = (s < 2) ? m_a[i][3:0] : m_a[i][7:4];
                ey = (s % 2 == 0) ? m_b[i][3:0] : m_b[i][7:4];
            end
            check($sformatf("cyc_in_ready%0d", i), 32'(rdy_v[i]), 32'(m_phase[i] == 0));
            check($sformatf("cyc_out_valid%0d", i), 32'(vld_v[i]), 32'(m_phase[i] == 2));
            check($sformatf("cyc_busy%0d", i), 32'(busy_v[i]), 32'(m_phase[i] != 0));
            check($sformatf("cyc_mul_x%0d", i), 32'(x_v[i]), 32'(ex));
            check($sformatf("cyc_mul_y%0d", i), 32'(y_v[i]), 32'(ey));
            if (!rst_n) check($sformatf("cyc_rst_out_p%0d", i), 32'(p_v[i]), 32'd0);
            if (m_phase[i] == 2) check($sformatf("cyc_out_p%0d", i), 32'(p_v[i]), 32'(m_prod[i]));
            if (rst_n && m_phase[i] == 2 && out_ready) begin
                check($sformatf("sb_order%0d", i), 32'(p_v[i]), 32'(exp_mem[i][hs_cnt[i] % 1024]));
                hs_cnt[i]++;
            end
        end
    end

    logic [7:0] seq0 [4];
    logic [7:0] seq2 [12];

    // Issue one request to both idle instances with out_ready high; check latency, product and operand schedule.
    task automatic run_req(input logic [7:0] a, input logic [7:0] b, input logic [15:0] want);
        int lat0, lat2;
        logic [15:0] p0, p2;
        logic [7:0] w;
        in_a = a;
        in_b = b;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_a = 8'($urandom);
        in_b = 8'($urandom);
        lat0 = -1; lat2 = -1; p0 = 16'd0; p2 = 16'd0;
        for (int c = 0; c < 16; c++) begin
            if (c < 4) seq0[c] = {mul_x0, mul_y0};
            if (c < 12) seq2[c] = {mul_x2, mul_y2};
            if (out_valid0 && lat0 < 0) begin lat0 = c; p0 = out_p0; end
            if (out_valid2 && lat2 < 0) begin lat2 = c; p2 = out_p2; end
            @(posedge clk); #1;
        end
        check("latency0", 32'(lat0), 32'd4);
        check("latency2", 32'(lat2), 32'd12);
        check("product0", 32'(p0), 32'(want));
        check("product2", 32'(p2), 32'(want));
        for (int c = 0; c < 12; c++) begin
            int s;
            s = c / 3;
            w = {((s < 2) ? a[3:0] : a[7:4]), ((s % 2 == 0) ? b[3:0] : b[7:4])};
            check("ops_sched2", 32'(seq2[c]), 32'(w));
            if (c < 4) begin
                w = {((c < 2) ? a[3:0] : a[7:4]), ((c % 2 == 0) ? b[3:0] : b[7:4])};
                check("ops_sched0", 32'(seq0[c]), 32'(w));
            end
        end
        check("idle_after0", 32'(in_ready0), 32'd1);
        check("idle_after2", 32'(in_ready2), 32'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready0"}, 32'(in_ready0), 32'd1);
        check({tag, "_in_ready2"}, 32'(in_ready2), 32'd1);
        check({tag, "_out_valid"}, {30'd0, out_valid0, out_valid2}, 32'd0);
        check({tag, "_busy"}, {30'd0, busy0, busy2}, 32'd0);
        check({tag, "_out_p"}, {out_p0, out_p2}, 32'd0);
        check({tag, "_mul_xy"}, {16'd0, mul_x0, mul_y0, mul_x2, mul_y2}, 32'd0);
    endtask

    initial begin
        int base;
        int drained;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        #2 rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed products with literal expectations.
        run_req(8'h12, 8'h34, 16'h03A8);
        check("seq_12x34", {seq0[0], seq0[1], seq0[2], seq0[3]}, 32'h24231413);
        run_req(8'hFF, 8'hFF, 16'hFE01);
        run_req(8'hA5, 8'h00, 16'h0000);
        run_req(8'h9C, 8'h47, 16'h2B44);
        check("seq_9Cx47_hold", {seq2[0], seq2[2], seq2[3], seq2[5]}, 32'hC7C7C4C4);
        check("seq_9Cx47_tail", {seq2[6], seq2[8], seq2[9], seq2[11]}, 32'h97979494);

        // Backpressure: 0x5A * 0xC3 = 0x448E held in DONE while new requests are offered.
        out_ready = 1'b0;
        in_a = 8'h5A; in_b = 8'hC3; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        check("bp_valid0", 32'(out_valid0), 32'd1);
        check("bp_valid2", 32'(out_valid2), 32'd1);
        for (int k = 0; k < 7; k++) begin
            in_valid = 1'b1;
            in_a = 8'($urandom);
            in_b = 8'($urandom);
            check("bp_hold_p0", 32'(out_p0), 32'h448E);
            check("bp_hold_p2", 32'(out_p2), 32'h448E);
            check("bp_in_ready", {30'd0, in_ready0, in_ready2}, 32'd0);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        check("bp_still_valid", {30'd0, out_valid0, out_valid2}, 32'd3);
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("bp_released_valid", {30'd0, out_valid0, out_valid2}, 32'd0);
        check("bp_released_ready", {30'd0, in_ready0, in_ready2}, 32'd3);
        @(posedge clk); #1;
        check("bp_single_hs", {30'd0, out_valid0, out_valid2}, 32'd0);
        out_ready = 1'b1;

        // Reset during step 2 of the combinational instance.
        in_a = 8'hFF; in_b = 8'hFF; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("pre_reset_busy", {30'd0, busy0, busy2}, 32'd3);
        #2 rst_n = 1'b0;
        #1;
        check_reset_outputs("midrun_reset");
        @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk); #1;
        run_req(8'h03, 8'h05, 16'h000F);

        // Random traffic with random valid/ready until the slow instance has taken 50 more requests.
        base = acc_cnt[1];
        for (int cyc = 0; cyc < 4000 && acc_cnt[1] < base + 50; cyc++) begin
            in_valid  = 1'($urandom_range(0, 1));
            in_a      = 8'($urandom);
            in_b      = 8'($urandom);
            out_ready = ($urandom_range(0, 2) != 0);
            @(posedge clk); #1;
        end
        check("rand_accepted", 32'(acc_cnt[1] >= base + 50), 32'd1);
        in_valid = 1'b0;
        out_ready = 1'b1;
        drained = 0;
        for (int cyc = 0; cyc < 40 && !drained; cyc++) begin
            @(posedge clk); #1;
            if (in_ready0 && in_ready2) drained = 1;
        end
        check("drain_idle", 32'(drained), 32'd1);
        check("no_drop0", 32'(hs_cnt[0]), 32'(acc_cnt[0]));
        check("no_drop2", 32'(hs_cnt[1]), 32'(acc_cnt[1]));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
